// File: rtl/rom_rd_mport.sv
// Multi-channel read front-end: round-robin arbitration of N_CH address streams onto one
// single-port ROM, with a credit-controlled response FIFO per channel.
module rom_rd_mport #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned W_DATA    = 13,
    parameter int unsigned W_ADDR    = 12,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned BUF_DEPTH = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_CH-1:0]        addr_valid_i,
    output logic [N_CH-1:0]        addr_ready_o,
    input  logic [N_CH*W_ADDR-1:0] addr_data_i,
    output logic [N_CH-1:0]        data_valid_o,
    input  logic [N_CH-1:0]        data_ready_i,
    output logic [N_CH*W_DATA-1:0] data_o,
    output logic                   rom_en_o,
    output logic [W_ADDR-1:0]      rom_addr_o,
    input  logic [W_DATA-1:0]      rom_data_i
);
    localparam int unsigned PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BUF_DEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BUF_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_CH - 1);

    logic                run_q;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    cnt_q    [N_CH];
    logic [CNT_W-1:0]    cnt_d    [N_CH];
    logic [CNT_W-1:0]    occ_q    [N_CH];
    logic [CNT_W-1:0]    occ_d    [N_CH];
    logic [IDX_W-1:0]    wr_ptr_q [N_CH];
    logic [IDX_W-1:0]    wr_ptr_d [N_CH];
    logic [IDX_W-1:0]    rd_ptr_q [N_CH];
    logic [IDX_W-1:0]    rd_ptr_d [N_CH];
    logic [W_DATA-1:0]   mem_q    [N_CH][BUF_DEPTH];
    logic                tag_vld_q [RD_LAT];
    logic [PTR_W-1:0]    tag_id_q  [RD_LAT];
    logic [N_CH-1:0]     elig, push, pop;
    logic                gnt_any;
    logic [PTR_W-1:0]    gnt_id, cand;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_LAST) ? '0 : p + IDX_W'(1);
    endfunction

    // Eligibility uses only registered credits, so data_ready never reaches addr_ready.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_CH; i++) begin
            elig[i] = run_q && addr_valid_i[i] && (cnt_q[i] < CNT_MAX);
        end
    end

    // Round-robin: scan downward so the candidate closest to rr_ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        for (int k = int'(N_CH) - 1; k >= 0; k--) begin
            cand = PTR_W'((int'(rr_ptr_q) + k) % int'(N_CH));
            if (elig[cand]) begin
                gnt_any = 1'b1;
                gnt_id  = cand;
            end
        end
    end

    always_comb begin
        addr_ready_o = '0;
        rom_en_o     = gnt_any;
        rom_addr_o   = '0;
        rr_ptr_d     = rr_ptr_q;
        if (gnt_any) begin
            addr_ready_o[gnt_id] = 1'b1;
            rom_addr_o           = addr_data_i[gnt_id*W_ADDR +: W_ADDR];
            rr_ptr_d             = (gnt_id == PTR_LAST) ? '0 : gnt_id + PTR_W'(1);
        end
    end

    // Response side: head of each FIFO is presented; data is zero while empty.
    always_comb begin
        data_valid_o = '0;
        data_o       = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (occ_q[i] != '0) begin
                data_valid_o[i]              = 1'b1;
                data_o[i*W_DATA +: W_DATA]   = mem_q[i][rd_ptr_q[i]];
            end
        end
    end

    always_comb begin
        push = '0;
        pop  = '0;
        for (int i = 0; i < N_CH; i++) begin
            push[i]     = tag_vld_q[RD_LAT-1] && (tag_id_q[RD_LAT-1] == PTR_W'(i));
            pop[i]      = data_valid_o[i] && data_ready_i[i];
            cnt_d[i]    = cnt_q[i];
            occ_d[i]    = occ_q[i];
            wr_ptr_d[i] = push[i] ? idx_inc(wr_ptr_q[i]) : wr_ptr_q[i];
            rd_ptr_d[i] = pop[i]  ? idx_inc(rd_ptr_q[i]) : rd_ptr_q[i];
            if (addr_ready_o[i] && !pop[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!addr_ready_o[i] && pop[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
            if (push[i] && !pop[i]) begin
                occ_d[i] = occ_q[i] + CNT_W'(1);
            end else if (!push[i] && pop[i]) begin
                occ_d[i] = occ_q[i] - CNT_W'(1);
            end
        end
    end

    // run_q holds off grants until the first edge after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q    <= 1'b0;
            rr_ptr_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]    <= '0;
                occ_q[i]    <= '0;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
            for (int s = 0; s < RD_LAT; s++) begin
                tag_vld_q[s] <= 1'b0;
                tag_id_q[s]  <= '0;
            end
        end else begin
            run_q    <= 1'b1;
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                occ_q[i]    <= occ_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
            end
            tag_vld_q[0] <= gnt_any;
            tag_id_q[0]  <= gnt_id;
            for (int s = 1; s < RD_LAT; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_id_q[s]  <= tag_id_q[s-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < N_CH; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= rom_data_i;
            end
        end
    end

    // Credits make a write into a full FIFO impossible.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < N_CH; i++) begin
            assert (!(rst_ni && push[i] && (occ_q[i] == CNT_MAX)));
        end
    end
endmodule

// File: tb/tb_rom_rd_mport.sv
// Bench for rom_rd_mport: queue-based reference model checked every cycle, plus directed
// literal checks. Instance A: 4 ch / RD_LAT 1 / depth 3. Instance B: 2 ch / RD_LAT 3 / depth 5.
module tb_rom_rd_mport;
    logic        clk, rst_n;
    logic [3:0]  a_av, a_ar, a_dv, a_dr, hs_a;
    logic [47:0] a_ad;
    logic [51:0] a_d;
    logic        a_en;
    logic [11:0] a_ra;
    logic [12:0] a_rd;
    logic [1:0]  b_av, b_ar, b_dv, b_dr, hs_b;
    logic [23:0] b_ad;
    logic [25:0] b_d;
    logic        b_en;
    logic [11:0] b_ra;
    logic [12:0] b_rd, b_p1, b_p2;
    bit          done;

    int n_cmp, n_bad, cyc;

    // Reference model state, index = inst*4 + channel
    int mq_v [8][$];
    int mq_t [8][$];
    int m_cred [8];
    int m_rr [2];
    bit m_live [2];

    // Observed statistics
    int acc_n [8], pop_n [8], f_acc [8], l_acc [8], f_dv [8];
    logic [12:0] plog [8][$];

    rom_rd_mport #(.N_CH(4), .W_DATA(13), .W_ADDR(12), .RD_LAT(1), .BUF_DEPTH(3)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .addr_valid_i(a_av), .addr_ready_o(a_ar), .addr_data_i(a_ad),
        .data_valid_o(a_dv), .data_ready_i(a_dr), .data_o(a_d), .rom_en_o(a_en), .rom_addr_o(a_ra),
        .rom_data_i(a_rd));

    rom_rd_mport #(.N_CH(2), .W_DATA(13), .W_ADDR(12), .RD_LAT(3), .BUF_DEPTH(5)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .addr_valid_i(b_av), .addr_ready_o(b_ar), .addr_data_i(b_ad),
        .data_valid_o(b_dv), .data_ready_i(b_dr), .data_o(b_d), .rom_en_o(b_en), .rom_addr_o(b_ra),
        .rom_data_i(b_rd));

    function automatic logic [12:0] rom_f(input logic [11:0] a);
        return 13'(a) - 13'd2048;
    endfunction

    // ROM models with read latency 1 and 3
    always @(posedge clk) begin
        a_rd <= rom_f(a_ra);
        b_p1 <= rom_f(b_ra);
        b_p2 <= b_p1;
        b_rd <= b_p2;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_step(input int s, input int n, input int lat, input int dep, input logic rstn,
                              input logic [3:0] av, input logic [47:0] ad, input logic [3:0] dr,
                              input logic [3:0] ar, input logic [3:0] dv, input logic [51:0] dd,
                              input logic en, input logic [11:0] ra);
        int g, ch;
        logic [3:0]  e_ar, e_dv;
        logic [51:0] e_d;
        logic        e_en;
        logic [11:0] e_ra;
        g = -1; e_ar = '0; e_dv = '0; e_d = '0; e_en = 1'b0; e_ra = '0;
        if (!rstn) begin
            for (int c = 0; c < 4; c++) begin
                mq_v[s*4+c].delete();
                mq_t[s*4+c].delete();
                m_cred[s*4+c] = 0;
            end
            m_rr[s] = 0;
            m_live[s] = 1'b0;
        end else begin
            if (m_live[s]) begin
                for (int k = 0; k < n; k++) begin
                    ch = (m_rr[s] + k) % n;
                    if (g < 0 && av[ch] && m_cred[s*4+ch] < dep) g = ch;
                end
            end
            if (g >= 0) begin
                e_ar[g] = 1'b1;
                e_en    = 1'b1;
                e_ra    = ad[g*12 +: 12];
            end
            for (int c = 0; c < n; c++) begin
                if (mq_v[s*4+c].size() > 0 && mq_t[s*4+c][0] <= cyc) begin
                    e_dv[c] = 1'b1;
                    e_d[c*13 +: 13] = 13'(mq_v[s*4+c][0]);
                end
            end
        end
        chk($sformatf("i%0d.addr_ready", s), 64'(ar), 64'(e_ar));
        chk($sformatf("i%0d.rom_en", s), 64'(en), 64'(e_en));
        chk($sformatf("i%0d.rom_addr", s), 64'(ra), 64'(e_ra));
        chk($sformatf("i%0d.data_valid", s), 64'(dv), 64'(e_dv));
        chk($sformatf("i%0d.data", s), 64'(dd), 64'(e_d));
        if (rstn) begin
            for (int c = 0; c < n; c++) begin
                if (e_dv[c] && dr[c]) begin
                    void'(mq_v[s*4+c].pop_front());
                    void'(mq_t[s*4+c].pop_front());
                    m_cred[s*4+c]--;
                end
            end
            if (g >= 0) begin
                mq_v[s*4+g].push_back(int'(rom_f(ad[g*12 +: 12])));
                mq_t[s*4+g].push_back(cyc + lat + 1);
                m_cred[s*4+g]++;
                m_rr[s] = (g + 1) % n;
            end
            m_live[s] = 1'b1;
        end
    endtask

    task automatic mon(input int s, input logic [3:0] av, input logic [3:0] ar, input logic [3:0] dv,
                       input logic [3:0] dr, input logic [51:0] dd);
        for (int c = 0; c < 4; c++) begin
            if (av[c] && ar[c]) begin
                acc_n[s*4+c]++;
                if (f_acc[s*4+c] < 0) f_acc[s*4+c] = cyc;
                l_acc[s*4+c] = cyc;
            end
            if (dv[c] && f_dv[s*4+c] < 0) f_dv[s*4+c] = cyc;
            if (dv[c] && dr[c]) begin
                pop_n[s*4+c]++;
                plog[s*4+c].push_back(dd[c*13 +: 13]);
            end
        end
    endtask

    // Single compare process: both instances against the model every cycle
    always @(negedge clk) begin
        model_step(0, 4, 1, 3, rst_n, a_av, a_ad, a_dr, a_ar, a_dv, a_d, a_en, a_ra);
        model_step(1, 2, 3, 5, rst_n, {2'b00, b_av}, {24'd0, b_ad}, {2'b00, b_dr},
                   {2'b00, b_ar}, {2'b00, b_dv}, {26'd0, b_d}, b_en, b_ra);
        mon(0, a_av, a_ar, a_dv, a_dr, a_d);
        mon(1, {2'b00, b_av}, {2'b00, b_ar}, {2'b00, b_dv}, {2'b00, b_dr}, {26'd0, b_d});
    end

    task automatic clr_stats();
        for (int i = 0; i < 8; i++) begin
            acc_n[i] = 0; pop_n[i] = 0; f_acc[i] = -1; l_acc[i] = -1; f_dv[i] = -1;
            plog[i].delete();
        end
    endtask

    function automatic logic [12:0] plog_at(input int idx, input int k);
        if (plog[idx].size() > k) return plog[idx][k];
        return 13'h1fff;
    endfunction

    task automatic step();
        @(negedge clk);
        hs_a = a_av & a_ar;
        hs_b = b_av & b_ar;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        a_av = '0; a_ad = '0; a_dr = '0; b_av = '0; b_ad = '0; b_dr = '0;
        clr_stats();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset.addr_ready", 64'(a_ar), 64'd0);
        chk("reset.data_valid", 64'(a_dv), 64'd0);
        chk("reset.rom_en", 64'(a_en), 64'd0);
        chk("reset.data", 64'(a_d), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single-channel stream, addresses 0..15
        clr_stats();
        a_dr = 4'hF; a_ad = '0; a_av = 4'b0001; done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            step();
            if (hs_a[0]) a_ad[11:0] = a_ad[11:0] + 12'd1;
            if (a_ad[11:0] == 12'd16) begin a_av = '0; done = 1'b1; end
        end
        chk("t1.done", 64'(done), 64'd1);
        repeat (6) step();
        chk("t1.accepts", 64'(acc_n[0]), 64'd16);
        chk("t1.span", 64'(l_acc[0] - f_acc[0]), 64'd15);
        chk("t1.latency", 64'(f_dv[0] - f_acc[0]), 64'd2);
        chk("t1.pops", 64'(pop_n[0]), 64'd16);
        chk("t1.first", 64'(plog_at(0, 0)), 64'(13'h1800));
        chk("t1.last", 64'(plog_at(0, 15)), 64'(13'h180F));

        // All four channels, fixed addresses 100+i, 40 cycles
        clr_stats();
        a_ad = {12'd103, 12'd102, 12'd101, 12'd100}; a_av = 4'hF; a_dr = 4'hF;
        repeat (40) step();
        a_av = '0;
        repeat (8) step();
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("t2.acc%0d", c), 64'(acc_n[c]), 64'd10);
            chk($sformatf("t2.pop%0d", c), 64'(pop_n[c]), 64'd10);
            chk($sformatf("t2.data%0d", c), 64'(plog_at(c, 0)), 64'(13'h1864 + 13'(c)));
        end

        // Channel 2 stalled on data_ready
        clr_stats();
        a_ad = {12'd1024, 12'd768, 12'd512, 12'd256}; a_av = 4'hF; a_dr = 4'b1011;
        for (int c = 0; c < 30; c++) begin
            step();
            for (int ch = 0; ch < 4; ch++) if (hs_a[ch]) a_ad[ch*12 +: 12] = a_ad[ch*12 +: 12] + 12'd1;
        end
        chk("t3.acc2", 64'(acc_n[2]), 64'd3);
        chk("t3.others", 64'(acc_n[0] + acc_n[1] + acc_n[3]), 64'd27);
        chk("t3.pop2", 64'(pop_n[2]), 64'd0);
        chk("t3.share", 64'(acc_n[0] >= 8 && acc_n[0] <= 10 && acc_n[1] >= 8 && acc_n[1] <= 10), 64'd1);
        a_dr = 4'hF;
        for (int c = 0; c < 10; c++) begin
            step();
            for (int ch = 0; ch < 4; ch++) if (hs_a[ch]) a_ad[ch*12 +: 12] = a_ad[ch*12 +: 12] + 12'd1;
        end
        chk("t3.held0", 64'(plog_at(2, 0)), 64'(13'h1B00));
        chk("t3.held1", 64'(plog_at(2, 1)), 64'(13'h1B01));
        chk("t3.held2", 64'(plog_at(2, 2)), 64'(13'h1B02));
        chk("t3.resume", 64'(acc_n[2] > 3), 64'd1);
        a_av = '0;
        repeat (8) step();

        // Reset with reads in flight and full FIFOs
        a_av = 4'hF; a_dr = 4'b1100;
        for (int c = 0; c < 12; c++) begin
            step();
            for (int ch = 0; ch < 4; ch++) if (hs_a[ch]) a_ad[ch*12 +: 12] = a_ad[ch*12 +: 12] + 12'd1;
        end
        rst_n = 1'b0;
        #1;
        chk("t4.addr_ready", 64'(a_ar), 64'd0);
        chk("t4.data_valid", 64'(a_dv), 64'd0);
        chk("t4.rom_en", 64'(a_en), 64'd0);
        chk("t4.rom_addr", 64'(a_ra), 64'd0);
        chk("t4.data", 64'(a_d), 64'd0);
        a_av = '0; a_dr = '0;
        repeat (3) step();
        rst_n = 1'b1;
        clr_stats();
        a_ad[11:0] = 12'd7; a_av = 4'b0001; a_dr = 4'hF; done = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            step();
            if (hs_a[0]) begin a_av = '0; done = 1'b1; end
        end
        chk("t4.done", 64'(done), 64'd1);
        repeat (6) step();
        chk("t4.pops", 64'(pop_n[0] + pop_n[1] + pop_n[2] + pop_n[3]), 64'd1);
        chk("t4.data", 64'(plog_at(0, 0)), 64'(13'h1807));

        // Random traffic on instance A; ready probability varies per 1000-cycle segment
        clr_stats();
        for (int c = 0; c < 10000; c++) begin
            a_av = 4'($urandom);
            for (int ch = 0; ch < 4; ch++) begin
                a_ad[ch*12 +: 12] = 12'($urandom);
                a_dr[ch] = ($urandom_range(0, 7) <= ((c / 1000) % 8));
            end
            step();
        end
        a_av = '0; a_dr = 4'hF;
        repeat (12) step();
        for (int ch = 0; ch < 4; ch++) begin
            chk($sformatf("t5.balance%0d", ch), 64'(pop_n[ch]), 64'(acc_n[ch]));
            chk($sformatf("t5.active%0d", ch), 64'(acc_n[ch] > 100), 64'd1);
        end

        // Instance B: latency 4, one accept per cycle on a single channel
        clr_stats();
        b_ad = {12'd0, 12'd40}; b_av = 2'b01; b_dr = 2'b11; done = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            step();
            if (hs_b[0]) b_ad[11:0] = b_ad[11:0] + 12'd1;
            if (b_ad[11:0] == 12'd60) begin b_av = '0; done = 1'b1; end
        end
        chk("t6.done", 64'(done), 64'd1);
        repeat (10) step();
        chk("t6.accepts", 64'(acc_n[4]), 64'd20);
        chk("t6.span", 64'(l_acc[4] - f_acc[4]), 64'd19);
        chk("t6.latency", 64'(f_dv[4] - f_acc[4]), 64'd4);
        chk("t6.pops", 64'(pop_n[4]), 64'd20);
        chk("t6.first", 64'(plog_at(4, 0)), 64'(13'h1828));
        chk("t6.last", 64'(plog_at(4, 19)), 64'(13'h183B));

        // Random traffic on instance B
        clr_stats();
        for (int c = 0; c < 2000; c++) begin
            b_av = 2'($urandom);
            for (int ch = 0; ch < 2; ch++) begin
                b_ad[ch*12 +: 12] = 12'($urandom);
                b_dr[ch] = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        b_av = '0; b_dr = 2'b11;
        repeat (15) step();
        for (int ch = 0; ch < 2; ch++) begin
            chk($sformatf("t7.balance%0d", ch), 64'(pop_n[4+ch]), 64'(acc_n[4+ch]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rom_rd_mport.md
# rom_rd_mport

Multi-channel read front-end for one single-port coefficient ROM (leaf/fail value tables). Up to N_CH independent valid/ready address streams share one ROM read port of configurable latency through a round-robin arbiter. Each channel gets its own credit-controlled output buffer, so backpressure on one channel never stalls the others. It replaces the single-stream read port plus output register used by the cascade classifier stages.

## Interface
- N_CH, 4, number of request/response channels (1..8)
- W_DATA, 13, ROM word width, signed
- W_ADDR, 12, ROM address width
- RD_LAT, 1, ROM read latency in cycles from rom_en to rom_data (1..4)
- BUF_DEPTH, 3, per-channel output buffer/credit depth; must be >= RD_LAT+2 for full per-channel throughput
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- addr_valid  in  N_CH  per-channel request valid
- addr_ready  out  N_CH  per-channel request accept
- addr_data  in  N_CH*W_ADDR  per-channel address, channel i at [i*W_ADDR +: W_ADDR]
- data_valid  out  N_CH  per-channel response valid
- data_ready  in  N_CH  per-channel response accept
- data  out  N_CH*W_DATA  per-channel signed response, channel i at [i*W_DATA +: W_DATA]
- rom_en  out  1  ROM read enable
- rom_addr  out  W_ADDR  ROM address
- rom_data  in  W_DATA  ROM read data, valid RD_LAT cycles after rom_en

## Operation
- Credit counter cnt[i] (0..BUF_DEPTH) per channel: +1 on accept, -1 on response pop (data_valid&data_ready), both in the same cycle leave it unchanged.
- Channel eligible when addr_valid[i] && cnt[i] < BUF_DEPTH, using the registered cnt only (no data_ready -> addr_ready path).
- Arbiter: at most one grant per cycle, round-robin starting at rr_ptr; addr_ready[i] = grant[i]. rr_ptr moves to (granted+1) mod N_CH on a grant, otherwise holds.
- On grant: rom_en=1, rom_addr=addr_data of the granted channel (combinational). No grant: rom_en=0, rom_addr=0.
- Tag pipeline: RD_LAT stages of {valid, channel id}; at stage RD_LAT, rom_data is written into that channel's FIFO.
- Per-channel FIFO, BUF_DEPTH entries, in order. data_valid[i] = FIFO non-empty, data = head entry. Credits guarantee a write is never dropped; a write to a full FIFO is a design error (assertion).
- Responses per channel return in request order. Across channels order follows grant order.
- N_CH=1: arbiter degenerates to pass-through gated by credit.

## Timing
- Reset (rst low, async): cnt=0, rr_ptr=0, tag pipeline cleared, FIFOs empty. Outputs: addr_ready=0, data_valid=0, data=0, rom_en=0, rom_addr=0. In-flight reads are discarded. Deassertion takes effect at the next clk edge.
- Latency: accept at cycle t -> data_valid at cycle t+RD_LAT+1 (RD_LAT=1: 2 cycles), when the FIFO was empty.
- Throughput: aggregate 1 read/cycle. A single channel sustains 1/cycle when BUF_DEPTH >= RD_LAT+2 and data_ready is held high.
- Handshake: data_valid, once high, holds with stable data until popped. addr_ready may depend on addr_valid. The arbiter never sees data_ready.
- Full: with data_ready[i]=0, channel i accepts exactly BUF_DEPTH requests then addr_ready[i]=0. One pop re-enables acceptance on the cycle after the pop.
- Simultaneous FIFO write and pop on the same channel: both happen, occupancy unchanged. Pop on a 1-entry FIFO with a concurrent write: the new entry is presented the next cycle.
- rr_ptr wraps N_CH-1 -> 0.

## Test plan
- Reset then ROM[k]=k-2048 (signed). Channel 0 streams addresses 0..15 back-to-back, data_ready=1 -> one accept per cycle, data 0..15 map to -2048..-2033 in order, first data_valid 2 cycles after the first accept.
- All 4 channels valid continuously, addresses 100+i -> grants rotate 0,1,2,3,0,... Each channel gets exactly 1/4 of the cycles over 40 cycles, and responses are routed to the correct channel.
- Channel 2 data_ready=0, others active -> channel 2 accepts exactly 3 requests then stalls. Channels 0,1,3 share the ROM at 1/3 each. Releasing data_ready yields the 3 held values in order, then acceptance resumes.
- Random valid/ready on all channels for 10k cycles against a scoreboard -> no loss, duplication or reordering per channel, and no FIFO overflow assertion.
- Assert rst low while 2 reads are in flight and 2 FIFOs are non-empty -> all outputs 0 immediately. After release, the first new request returns correct data with no stale responses.
- RD_LAT=3, BUF_DEPTH=5, N_CH=2 -> latency 4 cycles, and a single channel sustains 1/cycle.
